// File: rtl/ex_muldiv_unit.sv
// Iterative 32-cycle multiply/divide unit for the EX stage, owning the HI/LO registers.
// Shift-add multiply and restoring divide share one double-width accumulator.
module ex_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Start,
  input  logic [1:0]       Op,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic             Flush,
  input  logic             HiWrite,
  input  logic             LoWrite,
  input  logic [WIDTH-1:0] WriteData,
  output logic             Busy,
  output logic             StallReq,
  output logic             Done,
  output logic [WIDTH-1:0] HiOut,
  output logic [WIDTH-1:0] LoOut
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     orig_a;
  logic                 sign_a;
  logic                 sign_b;
  logic                 op_div;

  logic                 in_neg_a;
  logic                 in_neg_b;
  logic [WIDTH-1:0]     in_mag_a;
  logic [WIDTH-1:0]     in_mag_b;
  logic [WIDTH:0]       sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH:0]       diff;
  logic [2*WIDTH-1:0]   step;
  logic [2*WIDTH-1:0]   prod;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic [WIDTH-1:0]     res_hi;
  logic [WIDTH-1:0]     res_lo;

  assign Busy     = (state != IDLE);
  assign StallReq = Busy | (Start & (state == IDLE) & ~Flush);

  // Unsigned ops (Op[0]=1) take raw operands with no sign handling.
  always_comb begin
    in_neg_a = ~Op[0] & OperandA[WIDTH-1];
    in_neg_b = ~Op[0] & OperandB[WIDTH-1];
    in_mag_a = in_neg_a ? -OperandA : OperandA;
    in_mag_b = in_neg_b ? -OperandB : OperandB;
  end

  // Multiply: {hi,lo} with multiplier in lo, add into hi then shift right.
  // Divide: {rem,quo} shifted left, trial subtract restores on borrow.
  always_comb begin
    sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    diff   = rem_sh - {1'b0, mag_b};
    step   = '0;
    if (op_div) begin
      if (diff[WIDTH]) step = {acc[2*WIDTH-2:0], 1'b0};
      else             step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end else begin
      step = {sum, acc[WIDTH-1:1]};
    end
  end

  always_comb begin
    prod   = (sign_a ^ sign_b) ? -acc : acc;
    quo    = (sign_a ^ sign_b) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem    = sign_a ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    res_hi = prod[2*WIDTH-1:WIDTH];
    res_lo = prod[WIDTH-1:0];
    if (op_div) begin
      if (mag_b == '0) begin
        res_hi = orig_a;
        res_lo = '1;
      end else begin
        res_hi = rem;
        res_lo = quo;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      acc    <= '0;
      mag_a  <= '0;
      mag_b  <= '0;
      orig_a <= '0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      op_div <= 1'b0;
      HiOut  <= '0;
      LoOut  <= '0;
      Done   <= 1'b0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (HiWrite) HiOut <= WriteData;
          if (LoWrite) LoOut <= WriteData;
          if (Start && !Flush) begin
            state  <= CALC;
            cnt    <= '1;
            op_div <= Op[1];
            mag_a  <= in_mag_a;
            mag_b  <= in_mag_b;
            sign_a <= in_neg_a;
            sign_b <= in_neg_b;
            orig_a <= OperandA;
            acc    <= Op[1] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
          end
        end
        CALC: begin
          if (Flush) begin
            state <= IDLE;
          end else begin
            acc <= step;
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= FIX;
          end
        end
        FIX: begin
          state <= IDLE;
          if (!Flush) begin
            HiOut <= res_hi;
            LoOut <= res_lo;
            Done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Directed self-checking bench for ex_muldiv_unit: arithmetic results, latency,
// flush, reset, MTHI/MTLO and back-to-back issue.
module tb_ex_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        hi_wr;
  logic        lo_wr;
  logic [31:0] wdata;
  logic        busy;
  logic        stall;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [1:0] MULT = 2'b00, MULTU = 2'b01, DIV = 2'b10, DIVU = 2'b11;

  ex_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
    .Clk(clk), .Reset(rst), .Start(start), .Op(op), .OperandA(a), .OperandB(b),
    .Flush(flush), .HiWrite(hi_wr), .LoWrite(lo_wr), .WriteData(wdata),
    .Busy(busy), .StallReq(stall), .Done(done), .HiOut(hi), .LoOut(lo)
  );

  always #5 clk = ~clk;

  // Launch an op from the current cycle; returns cycles from Start to Done (0 on timeout)
  // and whether StallReq/Busy stayed high from the Start cycle through the last Busy cycle.
  task automatic do_op(input logic [1:0] o, input logic [31:0] opa, input logic [31:0] opb,
                       output int lat, output logic stall_ok);
    lat = 0;
    start = 1'b1; op = o; a = opa; b = opb;
    #1 stall_ok = stall;
    @(posedge clk); #1;
    start = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      if (done) begin
        lat = n;
        if (busy) stall_ok = 1'b0;
        break;
      end
      if (!(busy && stall)) stall_ok = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic write_hilo(input logic hw, input logic lw, input logic [31:0] d);
    hi_wr = hw; lo_wr = lw; wdata = d;
    @(posedge clk); #1;
    hi_wr = 1'b0; lo_wr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; op = 0; a = 0; b = 0; flush = 0; hi_wr = 0; lo_wr = 0; wdata = 0;
    repeat (2) @(posedge clk);
    #1;
    compared++; if ({busy, done, stall} !== 3'b000) begin mismatched++; $display("FAIL reset_ctl got %b want 000", {busy, done, stall}); end
    compared++; if (hi !== 32'h0) begin mismatched++; $display("FAIL reset_hi got %h want 00000000", hi); end
    compared++; if (lo !== 32'h0) begin mismatched++; $display("FAIL reset_lo got %h want 00000000", lo); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mult();
    int lat; logic ok;
    do_op(MULT, 32'hFFFFFFFD, 32'd5, lat, ok);
    compared++; if (lat !== 34) begin mismatched++; $display("FAIL mult_latency got %0d want 34", lat); end
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL mult_stall got %b want 1", ok); end
    compared++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFF1) begin mismatched++; $display("FAIL mult_neg got %h_%h want ffffffff_fffffff1", hi, lo); end
    do_op(MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, ok);
    compared++; if ({hi, lo} !== 64'hFFFFFFFE_00000001) begin mismatched++; $display("FAIL multu_max got %h_%h want fffffffe_00000001", hi, lo); end
    do_op(MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, ok);
    compared++; if ({hi, lo} !== 64'h00000000_00000001) begin mismatched++; $display("FAIL mult_m1 got %h_%h want 00000000_00000001", hi, lo); end
  endtask

  task automatic test_div();
    int lat; logic ok;
    do_op(DIV, 32'hFFFFFFF9, 32'd2, lat, ok);
    compared++; if (lat !== 34) begin mismatched++; $display("FAIL div_latency got %0d want 34", lat); end
    compared++; if ({hi, lo} !== 64'hFFFFFFFF_FFFFFFFD) begin mismatched++; $display("FAIL div_neg got %h_%h want ffffffff_fffffffd", hi, lo); end
    do_op(DIVU, 32'hFFFFFFF9, 32'd2, lat, ok);
    compared++; if ({hi, lo} !== 64'h00000001_7FFFFFFC) begin mismatched++; $display("FAIL divu got %h_%h want 00000001_7ffffffc", hi, lo); end
    do_op(DIVU, 32'h64, 32'd0, lat, ok);
    compared++; if (lat !== 34) begin mismatched++; $display("FAIL divz_latency got %0d want 34", lat); end
    compared++; if ({hi, lo} !== 64'h00000064_FFFFFFFF) begin mismatched++; $display("FAIL divu_zero got %h_%h want 00000064_ffffffff", hi, lo); end
    do_op(DIV, 32'hFFFFFF9C, 32'd0, lat, ok);
    compared++; if ({hi, lo} !== 64'hFFFFFF9C_FFFFFFFF) begin mismatched++; $display("FAIL div_zero got %h_%h want ffffff9c_ffffffff", hi, lo); end
    do_op(DIV, 32'h80000000, 32'hFFFFFFFF, lat, ok);
    compared++; if ({hi, lo} !== 64'h00000000_80000000) begin mismatched++; $display("FAIL div_ovf got %h_%h want 00000000_80000000", hi, lo); end
  endtask

  task automatic test_mthi_mtlo();
    write_hilo(1'b1, 1'b0, 32'h11);
    compared++; if ({hi, done} !== {32'h11, 1'b0}) begin mismatched++; $display("FAIL mthi got hi=%h done=%b want 00000011/0", hi, done); end
    write_hilo(1'b0, 1'b1, 32'h22);
    compared++; if ({hi, lo, done} !== {32'h11, 32'h22, 1'b0}) begin mismatched++; $display("FAIL mtlo got %h_%h done=%b want 00000011_00000022/0", hi, lo, done); end
    write_hilo(1'b1, 1'b1, 32'h33);
    compared++; if ({hi, lo} !== {32'h33, 32'h33}) begin mismatched++; $display("FAIL mthilo got %h_%h want 00000033_00000033", hi, lo); end
    write_hilo(1'b1, 1'b0, 32'h11);
    write_hilo(1'b0, 1'b1, 32'h22);
  endtask

  task automatic test_flush();
    int seen_done;
    seen_done = 0;
    start = 1'b1; op = DIV; a = 32'd100; b = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL flush_idle got busy=%b done=%b want 0/0", busy, done); end
    for (int n = 0; n < 40; n++) begin
      if (done || busy) seen_done++;
      @(posedge clk); #1;
    end
    compared++; if (seen_done !== 0) begin mismatched++; $display("FAIL flush_quiet got %0d active cycles want 0", seen_done); end
    compared++; if ({hi, lo} !== {32'h11, 32'h22}) begin mismatched++; $display("FAIL flush_hilo got %h_%h want 00000011_00000022", hi, lo); end
    start = 1'b1; flush = 1'b1; op = MULT; a = 32'd3; b = 32'd3;
    #1;
    compared++; if (stall !== 1'b0) begin mismatched++; $display("FAIL start_flush_stall got %b want 0", stall); end
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    compared++; if (busy !== 1'b0) begin mismatched++; $display("FAIL start_flush_busy got %b want 0", busy); end
  endtask

  task automatic test_hiwrite_busy();
    start = 1'b1; op = MULTU; a = 32'd3; b = 32'd4;
    hi_wr = 1'b1; wdata = 32'h77;
    @(posedge clk); #1;
    start = 1'b0; hi_wr = 1'b0;
    compared++; if ({busy, hi} !== {1'b1, 32'h77}) begin mismatched++; $display("FAIL start_mthi got busy=%b hi=%h want 1/00000077", busy, hi); end
    repeat (2) @(posedge clk);
    #1;
    hi_wr = 1'b1; lo_wr = 1'b1; wdata = 32'hAAAA;
    @(posedge clk); #1;
    hi_wr = 1'b0; lo_wr = 1'b0;
    compared++; if ({hi, lo} !== {32'h77, 32'h22}) begin mismatched++; $display("FAIL busy_write got %h_%h want 00000077_00000022", hi, lo); end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
  endtask

  task automatic test_reset_mid();
    write_hilo(1'b1, 1'b1, 32'h99);
    start = 1'b1; op = MULT; a = 32'd9; b = 32'd9;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    compared++; if ({busy, done} !== 2'b00) begin mismatched++; $display("FAIL reset_mid_ctl got busy=%b done=%b want 0/0", busy, done); end
    compared++; if ({hi, lo} !== 64'h0) begin mismatched++; $display("FAIL reset_mid_hilo got %h_%h want 00000000_00000000", hi, lo); end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat; logic ok;
    do_op(MULTU, 32'd6, 32'd7, lat, ok);
    compared++; if ({hi, lo} !== 64'd42) begin mismatched++; $display("FAIL b2b_first got %h_%h want 00000000_0000002a", hi, lo); end
    do_op(DIVU, 32'd100, 32'd7, lat, ok);
    compared++; if (lat !== 34) begin mismatched++; $display("FAIL b2b_latency got %0d want 34", lat); end
    compared++; if (ok !== 1'b1) begin mismatched++; $display("FAIL b2b_stall got %b want 1", ok); end
    compared++; if ({hi, lo} !== {32'd2, 32'd14}) begin mismatched++; $display("FAIL b2b_second got %h_%h want 00000002_0000000e", hi, lo); end
    @(posedge clk); #1;
    compared++; if (done !== 1'b0) begin mismatched++; $display("FAIL done_pulse got %b want 0", done); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_flush();
    test_hiwrite_busy();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- Iterative multiply/divide unit in the EX stage. It consumes the operands and control leaving the decode-to-execute pipeline register.
- Executes MULT/MULTU/DIV/DIVU over 33 cycles and owns the architectural HI/LO registers. Also services MTHI/MTLO writes.
- Raises StallReq so the hazard logic holds the upstream pipeline registers while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; log2(WIDTH).

Ports:
- Clk  input  1  rising-edge clock
- Reset  input  1  asynchronous, active-high reset
- Start  input  1  launch operation; sampled only in IDLE
- Op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
- OperandA  input  32  rs value (ReadData1Out of the ID/EX register)
- OperandB  input  32  rt value (ReadData2Out of the ID/EX register)
- Flush  input  1  cancel the in-flight operation (branch/jump squash)
- HiWrite  input  1  MTHI strobe
- LoWrite  input  1  MTLO strobe
- WriteData  input  32  data for MTHI/MTLO
- Busy  output  1  state != IDLE
- StallReq  output  1  Busy | (Start & state==IDLE & ~Flush), combinational
- Done  output  1  one-cycle registered pulse when HI/LO take a result
- HiOut  output  32  HI register
- LoOut  output  32  LO register

Behaviour:
- Reset: asynchronous and active-high. Forces state=IDLE, counter=0, HiOut=0, LoOut=0, Done=0, and clears the internal accumulator/remainder. Reset asserted mid-operation aborts it; HI/LO read 0 afterwards.
- States: IDLE, CALC, FIX.
  - IDLE -> CALC on an edge with Start=1 and Flush=0. Latch Op, |A|, |B|, the sign bits and the original OperandA; counter=31.
  - CALC: one iteration per edge. Counter decrements. At counter==0 the iteration runs, then -> FIX.
  - FIX -> IDLE: apply sign correction, write HiOut/LoOut, set Done=1 for exactly one cycle.
- Latency: Start sampled at edge E0, iterations at E1..E32, result and Done registered at E33. Busy is high for 33 cycles. Done is high during the cycle after E33.
- Multiply: 32-step shift-add on unsigned magnitudes into a 64-bit product.
  - MULT negates the product when signA^signB. MULTU uses raw operands, no sign handling.
  - Result: HI=product[63:32], LO=product[31:0].
- Divide: 32-step restoring division on magnitudes. DIVU uses raw operands.
  - DIV signs: quotient negated when signA^signB; remainder takes the sign of A.
  - Result: LO=quotient, HI=remainder.
  - 0x80000000 / 0xFFFFFFFF (DIV): LO=0x80000000, HI=0. This falls out of the magnitude path and needs no special case.
- Divide by zero (DIV or DIVU, B==0): the operation still takes the full 33 cycles. Result is HI=original OperandA, LO=0xFFFFFFFF.
- Start while Busy: ignored; not queued.
- Flush:
  - In CALC or FIX: at the next edge, state=IDLE, HI/LO unchanged, no Done.
  - In IDLE with Start: Flush wins; nothing launches.
- HiWrite/LoWrite:
  - In IDLE: update the register at the edge.
  - While Busy: ignored.
  - HiWrite and LoWrite together: both registers update.
- Start and HiWrite in the same IDLE cycle: both take effect. The operation later overwrites HI at E33.
- Done is never asserted for MTHI/MTLO.
- Back-to-back: Start may be asserted in the cycle Done is high (state is already IDLE), giving zero idle gap.

Test Plan:
- MULT A=0xFFFFFFFD(-3), B=5 -> HiOut=0xFFFFFFFF, LoOut=0xFFFFFFF1. Done exactly 34 cycles after Start is asserted; StallReq high from the Start cycle through the last Busy cycle.
- MULTU A=B=0xFFFFFFFF -> HiOut=0xFFFFFFFE, LoOut=0x00000001. MULT with the same operands -> HiOut=0, LoOut=1.
- DIV A=0xFFFFFFF9(-7), B=2 -> LoOut=0xFFFFFFFD, HiOut=0xFFFFFFFF. DIVU with the same operands -> LoOut=0x7FFFFFFC, HiOut=0x00000001.
- DIVU A=0x64, B=0 -> HiOut=0x64, LoOut=0xFFFFFFFF. DIV A=0x80000000, B=0xFFFFFFFF -> LoOut=0x80000000, HiOut=0.
- Preload with MTHI=0x11, MTLO=0x22. Start DIV 100/7, then Flush on the 10th CALC cycle -> Busy low next cycle, no Done, HI/LO stay 0x11/0x22. Start+Flush in the same cycle -> Busy never rises.
- Assert Reset mid-CALC -> Busy=0, Done=0, HI=LO=0 immediately (asynchronous). HiWrite during Busy is ignored. Start in the Done cycle launches a second op with no idle gap.
